// File: rtl/mad_arbiter.sv
// Round-robin arbiter that shares one external multiply-add datapath between
// NUM_REQ requesters, with a per-requester 32-bit accumulator and a tagged response port.
module mad_arbiter #(
    parameter int unsigned  NUM_REQ  = 2,
    parameter int unsigned  ID_WIDTH = 3,
    localparam int unsigned IDX_W    = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
    input  logic                         clk_i,
    input  logic                         rst_ni,
    input  logic [NUM_REQ-1:0]           req_valid_i,
    output logic [NUM_REQ-1:0]           req_ready_o,
    input  logic [NUM_REQ*32-1:0]        req_a_i,
    input  logic [NUM_REQ*32-1:0]        req_b_i,
    input  logic [NUM_REQ*ID_WIDTH-1:0]  req_id_i,
    input  logic [NUM_REQ-1:0]           req_acc_i,
    input  logic                         flush_i,
    output logic                         mad_valid_o,
    output logic [31:0]                  mad_a_o,
    output logic [31:0]                  mad_b_o,
    input  logic                         mad_result_valid_i,
    input  logic [31:0]                  mad_result_i,
    output logic                         resp_valid_o,
    input  logic                         resp_ready_i,
    output logic [31:0]                  resp_result_o,
    output logic [ID_WIDTH-1:0]          resp_id_o,
    output logic [IDX_W-1:0]             resp_req_o,
    output logic                         busy_o
);

    // Handshakes: a transfer happens on a rising clock edge where valid and ready
    // are both high. Once raised, valid and its payload stay stable until that edge.

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        RESP  = 2'd2
    } state_e;

    state_e                state_q, state_d;
    logic [IDX_W-1:0]      rr_ptr_q, rr_ptr_d;
    logic [31:0]           op_a_q, op_a_d;
    logic [31:0]           op_b_q, op_b_d;
    logic [ID_WIDTH-1:0]   op_id_q, op_id_d;
    logic                  op_acc_q, op_acc_d;
    logic [IDX_W-1:0]      op_idx_q, op_idx_d;
    logic                  kill_q, kill_d;
    logic [31:0]           accum_q [NUM_REQ];
    logic [31:0]           accum_d [NUM_REQ];
    logic [31:0]           resp_result_q, resp_result_d;
    logic [ID_WIDTH-1:0]   resp_id_q, resp_id_d;
    logic [IDX_W-1:0]      resp_req_q, resp_req_d;

    logic                  found;
    logic [IDX_W-1:0]      winner;
    logic [31:0]           final_sum;
    logic                  drop_result;

    // Search starts at rr_ptr and wraps, so the last winner has lowest priority next time.
    always_comb begin
        logic [31:0]      cand;
        logic [IDX_W-1:0] cand_idx;
        found    = 1'b0;
        winner   = '0;
        cand     = '0;
        cand_idx = '0;
        for (int unsigned i = 0; i < NUM_REQ; i++) begin
            cand     = (32'(rr_ptr_q) + i) % NUM_REQ;
            cand_idx = cand[IDX_W-1:0];
            if (!found && req_valid_i[cand_idx]) begin
                found  = 1'b1;
                winner = cand_idx;
            end
        end
    end

    assign final_sum   = op_acc_q ? (accum_q[op_idx_q] + mad_result_i) : mad_result_i;
    assign drop_result = kill_q | flush_i;

    // FSM: state register
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // FSM: next state
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: begin
                if (found) state_d = ISSUE;
            end
            ISSUE: begin
                if (mad_result_valid_i) state_d = drop_result ? IDLE : RESP;
            end
            RESP: begin
                if (flush_i || resp_ready_i) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // FSM: outputs
    always_comb begin
        req_ready_o  = '0;
        mad_valid_o  = 1'b0;
        resp_valid_o = 1'b0;
        busy_o       = (state_q != IDLE);
        case (state_q)
            IDLE: begin
                if (found) req_ready_o[winner] = 1'b1;
            end
            ISSUE:   mad_valid_o  = 1'b1;
            RESP:    resp_valid_o = 1'b1;
            default: ;
        endcase
    end

    // Operand capture, accumulator update and response payload.
    always_comb begin
        rr_ptr_d      = rr_ptr_q;
        op_a_d        = op_a_q;
        op_b_d        = op_b_q;
        op_id_d       = op_id_q;
        op_acc_d      = op_acc_q;
        op_idx_d      = op_idx_q;
        kill_d        = kill_q;
        accum_d       = accum_q;
        resp_result_d = resp_result_q;
        resp_id_d     = resp_id_q;
        resp_req_d    = resp_req_q;
        case (state_q)
            IDLE: begin
                kill_d = 1'b0;
                if (found) begin
                    op_a_d   = req_a_i[32*winner +: 32];
                    op_b_d   = req_b_i[32*winner +: 32];
                    op_id_d  = req_id_i[ID_WIDTH*winner +: ID_WIDTH];
                    op_acc_d = req_acc_i[winner];
                    op_idx_d = winner;
                    rr_ptr_d = (winner == IDX_W'(NUM_REQ - 1)) ? '0 : winner + 1'b1;
                end
            end
            ISSUE: begin
                if (mad_result_valid_i) begin
                    kill_d = 1'b0;
                    // A killed operation still consumes its result so the datapath drains cleanly.
                    if (!drop_result) begin
                        accum_d[op_idx_q] = final_sum;
                        resp_result_d     = final_sum;
                        resp_id_d         = op_id_q;
                        resp_req_d        = op_idx_q;
                    end
                end else if (flush_i) begin
                    kill_d = 1'b1;
                end
            end
            default: kill_d = 1'b0;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            rr_ptr_q      <= '0;
            op_a_q        <= '0;
            op_b_q        <= '0;
            op_id_q       <= '0;
            op_acc_q      <= 1'b0;
            op_idx_q      <= '0;
            kill_q        <= 1'b0;
            resp_result_q <= '0;
            resp_id_q     <= '0;
            resp_req_q    <= '0;
            for (int unsigned i = 0; i < NUM_REQ; i++) begin
                accum_q[i] <= '0;
            end
        end else begin
            rr_ptr_q      <= rr_ptr_d;
            op_a_q        <= op_a_d;
            op_b_q        <= op_b_d;
            op_id_q       <= op_id_d;
            op_acc_q      <= op_acc_d;
            op_idx_q      <= op_idx_d;
            kill_q        <= kill_d;
            resp_result_q <= resp_result_d;
            resp_id_q     <= resp_id_d;
            resp_req_q    <= resp_req_d;
            for (int unsigned i = 0; i < NUM_REQ; i++) begin
                accum_q[i] <= accum_d[i];
            end
        end
    end

    assign mad_a_o       = op_a_q;
    assign mad_b_o       = op_b_q;
    assign resp_result_o = resp_result_q;
    assign resp_id_o     = resp_id_q;
    assign resp_req_o    = resp_req_q;

endmodule

// File: tb/tb_mad_arbiter.sv
// Directed bench for mad_arbiter with a 2-cycle byte-lane multiply-add datapath model
// and hand-computed expected results.
module tb_mad_arbiter;

    localparam int NR = 2;
    localparam int IW = 3;

    logic              clk_i = 1'b0;
    logic              rst_ni;
    logic [NR-1:0]     req_valid_i;
    logic [NR-1:0]     req_ready_o;
    logic [NR*32-1:0]  req_a_i;
    logic [NR*32-1:0]  req_b_i;
    logic [NR*IW-1:0]  req_id_i;
    logic [NR-1:0]     req_acc_i;
    logic              flush_i;
    logic              mad_valid_o;
    logic [31:0]       mad_a_o;
    logic [31:0]       mad_b_o;
    logic              mad_result_valid_i;
    logic [31:0]       mad_result_i;
    logic              resp_valid_o;
    logic              resp_ready_i;
    logic [31:0]       resp_result_o;
    logic [IW-1:0]     resp_id_o;
    logic [0:0]        resp_req_o;
    logic              busy_o;

    int cyc = 0;
    int n_checks = 0;
    int n_pass = 0;
    logic [31:0] exp_q[$];
    logic [31:0] res_q[$];

    mad_arbiter #(.NUM_REQ(NR), .ID_WIDTH(IW)) dut (
        .clk_i              (clk_i),
        .rst_ni             (rst_ni),
        .req_valid_i        (req_valid_i),
        .req_ready_o        (req_ready_o),
        .req_a_i            (req_a_i),
        .req_b_i            (req_b_i),
        .req_id_i           (req_id_i),
        .req_acc_i          (req_acc_i),
        .flush_i            (flush_i),
        .mad_valid_o        (mad_valid_o),
        .mad_a_o            (mad_a_o),
        .mad_b_o            (mad_b_o),
        .mad_result_valid_i (mad_result_valid_i),
        .mad_result_i       (mad_result_i),
        .resp_valid_o       (resp_valid_o),
        .resp_ready_i       (resp_ready_i),
        .resp_result_o      (resp_result_o),
        .resp_id_o          (resp_id_o),
        .resp_req_o         (resp_req_o),
        .busy_o             (busy_o)
    );

    // clock / reset timebase
    initial forever #5 clk_i = ~clk_i;
    always @(posedge clk_i) cyc <= cyc + 1;

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish, got timeout required completion");
        $fatal(1, "watchdog");
    end

    function automatic logic [31:0] dot4(input logic [31:0] a, input logic [31:0] b);
        int s;
        logic [7:0] ab;
        logic signed [7:0] bb;
        s = 0;
        for (int i = 0; i < 4; i++) begin
            ab = a[8*i +: 8];
            bb = b[8*i +: 8];
            s  = s + int'(ab) * int'(bb);
        end
        return 32'(s);
    endfunction

    // datapath model: result strobes in the third cycle of mad_valid_o
    initial begin
        int cnt;
        cnt = 0;
        mad_result_valid_i = 1'b0;
        mad_result_i       = '0;
        forever begin
            @(posedge clk_i);
            #1;
            if (mad_valid_o) cnt++;
            else cnt = 0;
            mad_result_valid_i = mad_valid_o && (cnt == 3);
            mad_result_i       = mad_result_valid_i ? dot4(mad_a_o, mad_b_o) : 32'h0;
        end
    end

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        n_checks++;
        if (obs !== exp_v)
            $display("FAIL %s: got 0x%08h expected 0x%08h (cycle %0d)", tag, obs, exp_v, cyc);
        else
            n_pass++;
    endtask

    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    task automatic smp();
        @(negedge clk_i);
    endtask

    // driver tasks
    task automatic issue(input int r, input logic [31:0] a, input logic [31:0] b,
                         input int id, input bit acc);
        req_a_i[32*r +: 32] = a;
        req_b_i[32*r +: 32] = b;
        req_id_i[IW*r +: IW] = IW'(id);
        req_acc_i[r]        = acc;
        req_valid_i[r]      = 1'b1;
    endtask

    task automatic await_grant(input int r, output int t, input string tag);
        bit ok;
        ok = 1'b0;
        t  = 0;
        for (int k = 0; k < 30; k++) begin
            smp();
            if (req_ready_o[r]) begin
                ok = 1'b1;
                break;
            end
            tick();
        end
        t = cyc;
        check_eq({tag, "_grant"}, 32'(ok), 32'd1);
    endtask

    task automatic wait_resp(input string tag);
        bit got;
        got = 1'b0;
        for (int k = 0; k < 30; k++) begin
            smp();
            if (resp_valid_o) begin
                got = 1'b1;
                break;
            end
            tick();
        end
        check_eq({tag, "_resp_seen"}, 32'(got), 32'd1);
    endtask

    // Called at T+1 after a grant at T; ends at the negedge of T+5.
    task automatic collect_resp(input int t, input int r, input int id,
                                input logic [31:0] exp_v, input string tag);
        int mv;
        bit got;
        mv  = 0;
        got = 1'b0;
        for (int k = 0; k < 30; k++) begin
            smp();
            if (resp_valid_o) begin
                got = 1'b1;
                break;
            end
            if (mad_valid_o) mv++;
            tick();
        end
        check_eq({tag, "_resp_seen"}, 32'(got), 32'd1);
        check_eq({tag, "_lat"}, 32'(cyc - t), 32'd4);
        check_eq({tag, "_mad_cycles"}, 32'(mv), 32'd3);
        check_eq({tag, "_result"}, resp_result_o, exp_v);
        check_eq({tag, "_id"}, 32'(resp_id_o), 32'(id));
        check_eq({tag, "_req"}, 32'(resp_req_o), 32'(r));
        tick();
        smp();
        check_eq({tag, "_idle_t5"}, 32'(busy_o), 32'd0);
    endtask

    task automatic do_op(input int r, input logic [31:0] a, input logic [31:0] b,
                         input int id, input bit acc, input logic [31:0] exp_v,
                         input string tag);
        int t;
        issue(r, a, b, id, acc);
        await_grant(r, t, tag);
        tick();
        req_valid_i[r] = 1'b0;
        collect_resp(t, r, id, exp_v, tag);
        tick();
    endtask

    initial begin
        int t;
        int t0;
        int grants;
        int resps;
        int lastg;
        int gidx;
        bit multi;
        bit hold_ok;

        rst_ni       = 1'b0;
        req_valid_i  = '0;
        req_a_i      = '0;
        req_b_i      = '0;
        req_id_i     = '0;
        req_acc_i    = '0;
        flush_i      = 1'b0;
        resp_ready_i = 1'b1;

        repeat (3) @(posedge clk_i);
        smp();
        check_eq("rst_busy", 32'(busy_o), 32'd0);
        check_eq("rst_mad_valid", 32'(mad_valid_o), 32'd0);
        check_eq("rst_resp_valid", 32'(resp_valid_o), 32'd0);
        check_eq("rst_req_ready", 32'(req_ready_o), 32'd0);
        check_eq("rst_resp_result", resp_result_o, 32'd0);
        check_eq("rst_mad_a", mad_a_o, 32'd0);
        tick();
        rst_ni = 1'b1;
        tick();

        // single operation and signed lanes
        do_op(0, 32'h01010101, 32'h02020202, 5, 1'b0, 32'h00000008, "single");
        do_op(0, 32'h01010101, 32'hFFFFFFFF, 1, 1'b0, 32'hFFFFFFFC, "signed_m1");
        do_op(0, 32'h000000FF, 32'h00000080, 2, 1'b0, 32'hFFFF8080, "signed_255x128");

        // accumulate: requester 0 interleaved with requester 1
        do_op(1, 32'h01010101, 32'h02020202, 3, 1'b0, 32'h00000008, "acc_r1_load");
        do_op(0, 32'h01010101, 32'h02020202, 4, 1'b1, 32'hFFFF8088, "acc_r0_add");
        do_op(1, 32'h01010101, 32'h02020202, 6, 1'b1, 32'h00000010, "acc_r1_add");

        // round-robin with both requesters valid continuously
        exp_q = '{32'd0, 32'd1, 32'd0, 32'd1};
        issue(0, 32'h01010101, 32'h01010101, 0, 1'b0);
        issue(1, 32'h02020202, 32'h01010101, 1, 1'b0);
        grants = 0;
        resps  = 0;
        lastg  = 0;
        multi  = 1'b0;
        for (int k = 0; k < 80; k++) begin
            smp();
            if ($countones(req_ready_o) > 1) multi = 1'b1;
            if (req_ready_o != '0 && grants < 4) begin
                gidx = req_ready_o[1] ? 1 : 0;
                check_eq("rr_order", 32'(gidx), exp_q.pop_front());
                if (grants > 0) check_eq("rr_spacing", 32'(cyc - lastg), 32'd5);
                lastg = cyc;
                grants++;
                res_q.push_back(gidx == 0 ? 32'h4 : 32'h8);
            end
            if (resp_valid_o && resp_ready_i && res_q.size() > 0) begin
                check_eq("rr_result", resp_result_o, res_q.pop_front());
                resps++;
            end
            if (resps == 4) break;
            tick();
            if (grants == 4) req_valid_i = '0;
        end
        check_eq("rr_resp_count", 32'(resps), 32'd4);
        check_eq("rr_ready_onehot", 32'(multi), 32'd0);
        tick();
        req_valid_i = '0;

        // backpressure: response held 10 cycles, waiting requester not granted
        resp_ready_i = 1'b0;
        issue(1, 32'h01010101, 32'h01010101, 3, 1'b1);
        await_grant(1, t, "bp");
        tick();
        req_valid_i[1] = 1'b0;
        issue(0, 32'h01010101, 32'h01010101, 6, 1'b1);
        wait_resp("bp");
        check_eq("bp_lat", 32'(cyc - t), 32'd4);
        hold_ok = 1'b1;
        for (int k = 0; k < 10; k++) begin
            tick();
            smp();
            if (!resp_valid_o || resp_result_o !== 32'hC || resp_id_o !== 3'd3 ||
                resp_req_o !== 1'b1 || req_ready_o !== '0)
                hold_ok = 1'b0;
        end
        check_eq("bp_hold_stable", 32'(hold_ok), 32'd1);
        check_eq("bp_result", resp_result_o, 32'h0000000C);
        tick();
        resp_ready_i = 1'b1;
        await_grant(0, t, "bp_next");
        tick();
        req_valid_i[0] = 1'b0;
        collect_resp(t, 0, 6, 32'h00000008, "bp_r0");
        tick();

        // flush during ISSUE at T+2
        issue(1, 32'h01010101, 32'h01010101, 5, 1'b1);
        await_grant(1, t, "fl");
        tick();
        req_valid_i[1] = 1'b0;
        tick();
        flush_i = 1'b1;
        smp();
        check_eq("fl_mad_valid_t2", 32'(mad_valid_o), 32'd1);
        tick();
        flush_i = 1'b0;
        smp();
        check_eq("fl_mad_valid_t3", 32'(mad_valid_o), 32'd1);
        check_eq("fl_no_resp_t3", 32'(resp_valid_o), 32'd0);
        tick();
        smp();
        check_eq("fl_idle_t4", 32'(busy_o), 32'd0);
        check_eq("fl_no_resp_t4", 32'(resp_valid_o), 32'd0);
        tick();
        do_op(1, 32'h01010101, 32'h01010101, 1, 1'b1, 32'h00000010, "fl_acc_kept");

        // flush during RESP drops the response but keeps the accumulator update
        resp_ready_i = 1'b0;
        issue(0, 32'h01010101, 32'h01010101, 2, 1'b1);
        await_grant(0, t, "fr");
        tick();
        req_valid_i[0] = 1'b0;
        wait_resp("fr");
        check_eq("fr_result", resp_result_o, 32'h0000000C);
        tick();
        flush_i = 1'b1;
        smp();
        check_eq("fr_resp_before_flush", 32'(resp_valid_o), 32'd1);
        tick();
        flush_i      = 1'b0;
        resp_ready_i = 1'b1;
        smp();
        check_eq("fr_dropped", 32'(resp_valid_o), 32'd0);
        check_eq("fr_idle", 32'(busy_o), 32'd0);
        tick();
        do_op(0, 32'h01010101, 32'h01010101, 3, 1'b1, 32'h00000010, "fr_acc_kept");

        // reset in the middle of an operation
        issue(0, 32'h02020202, 32'h02020202, 7, 1'b0);
        await_grant(0, t, "mr");
        tick();
        req_valid_i = '0;
        tick();
        rst_ni = 1'b0;
        #1;
        check_eq("mr_mad_valid", 32'(mad_valid_o), 32'd0);
        check_eq("mr_busy", 32'(busy_o), 32'd0);
        check_eq("mr_resp_valid", 32'(resp_valid_o), 32'd0);
        check_eq("mr_mad_a", mad_a_o, 32'd0);
        check_eq("mr_resp_result", resp_result_o, 32'd0);
        tick();
        rst_ni = 1'b1;
        issue(1, 32'h01010101, 32'h01010101, 2, 1'b1);
        issue(0, 32'h01010101, 32'h01010101, 4, 1'b1);
        t0 = cyc;
        await_grant(0, t, "mr_first");
        check_eq("mr_first_grant_cycle", 32'(t - t0), 32'd0);
        tick();
        req_valid_i[0] = 1'b0;
        collect_resp(t, 0, 4, 32'h00000004, "mr_acc0");
        check_eq("mr_next_grant_r1", 32'(req_ready_o), 32'd2);
        t = cyc;
        tick();
        req_valid_i[1] = 1'b0;
        collect_resp(t, 1, 2, 32'h00000004, "mr_acc1");
        tick();

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
